aud_pwm_sched: RTL

Round-robin scheduler that shares the single audio PWM player (aud_pwm: clk, rstn, start) between NUM_REQ requesters.
- Grants the player to one requester at a time.
- Sequences the player for each grant: reset pulse, then timed start window, then a fixed guard gap.
- Reports completion per requester.
- Sits between per-source control logic (APB wrappers, timers) and the aud_pwm instance; drives its rstn and start.

---
 rtl/aud_pwm_sched.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/aud_pwm_sched.sv
// Round-robin scheduler sharing one aud_pwm player between NUM_REQ requesters.
// Each grant is sequenced as a player reset pulse, a timed start window and a
// fixed idle guard gap. Completion is signalled to the owner with a 1-cycle
// done pulse. An abort or the owner dropping its request ends the grant early
// with no done pulse. All outputs come straight from flops.
module aud_pwm_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DUR_W      = 24,
   parameter int RST_CYCLES = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic                       pclk_i,
   input  logic                       presetn_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*DUR_W-1:0]   dur_i,
   input  logic                       abort_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [NUM_REQ-1:0]         done_o,
   output logic [$clog2(NUM_REQ)-1:0] owner_o,
   output logic                       busy_o,
   output logic                       aud_rstn_o,
   output logic                       aud_start_o
);

   localparam int OWN_W = $clog2(NUM_REQ);
   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int CG_W  = (RST_W > GAP_W) ? RST_W : GAP_W;
   localparam int CNT_W = (DUR_W > CG_W) ? DUR_W : CG_W;

   // Counters are loaded with length-1 and the state ends when they reach 0.
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_PLAY  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [OWN_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic               busy_q, busy_d;
   logic               rstn_q, rstn_d;
   logic               start_q, start_d;

   logic               pick_vld;
   logic [OWN_W-1:0]   pick_idx;
   logic [OWN_W-1:0]   pick_ptr;
   logic [NUM_REQ-1:0] pick_oh;
   logic [DUR_W-1:0]   pick_dur;
   int                 arb_cand;
   int                 arb_nxt;

   // Round-robin search: first active request at or after the pointer, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      arb_cand = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_cand = int'(ptr_q) + i;
         if (arb_cand >= NUM_REQ) arb_cand = arb_cand - NUM_REQ;
         if (!pick_vld && req_i[OWN_W'(arb_cand)]) begin
            pick_vld = 1'b1;
            pick_idx = OWN_W'(arb_cand);
         end
      end
   end

   // Decode the winner: one-hot grant, its duration slice and the next pointer.
   always_comb begin
      pick_oh  = '0;
      pick_dur = '0;
      arb_nxt  = int'(pick_idx) + 1;
      if (arb_nxt >= NUM_REQ) arb_nxt = 0;
      pick_ptr = OWN_W'(arb_nxt);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == OWN_W'(k)) begin
            pick_oh[k] = 1'b1;
            pick_dur   = dur_i[k*DUR_W +: DUR_W];
         end
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      owner_d = owner_q;
      rstn_d  = rstn_q;
      start_d = start_q;
      case (state_q)
         S_IDLE: begin
            rstn_d  = 1'b1;
            start_d = 1'b0;
            if (pick_vld) begin
               owner_d = pick_idx;
               gnt_d   = pick_oh;
               ptr_d   = pick_ptr;
               dur_d   = pick_dur;
               if (pick_dur == '0) begin
                  // Nothing to play: complete immediately and still take the gap.
                  state_d = S_GAP;
                  cnt_d   = GAP_LOAD;
                  done_d  = pick_oh;
               end else begin
                  state_d = S_RESET;
                  cnt_d   = RST_LOAD;
                  rstn_d  = 1'b0;
               end
            end
         end
         S_RESET: begin
            if (abort_i || !req_i[owner_q]) begin
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
               gnt_d   = '0;
               rstn_d  = 1'b1;
               start_d = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = S_PLAY;
               cnt_d   = CNT_W'(dur_q) - CNT_W'(1);
               rstn_d  = 1'b1;
               start_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_PLAY: begin
            // Abort is tested first so it beats a coincident final play cycle.
            if (abort_i || !req_i[owner_q]) begin
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
               gnt_d   = '0;
               start_d = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = S_GAP;
               cnt_d   = GAP_LOAD;
               gnt_d   = '0;
               start_d = 1'b0;
               done_d  = gnt_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            gnt_d   = '0;
            rstn_d  = 1'b1;
            start_d = 1'b0;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset holds the player in reset.
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dur_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         rstn_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dur_q   <= dur_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         rstn_q  <= rstn_d;
         start_q <= start_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign owner_o     = owner_q;
   assign busy_o      = busy_q;
   assign aud_rstn_o  = rstn_q;
   assign aud_start_o = start_q;

endmodule
